// File: rtl/link_flag_transceiver.sv
// link_flag_transceiver: exchanges three status flags with a peer board
// over a repeating 6-bit serial frame (start, 3 data, even parity, stop).
module link_flag_transceiver #(
    parameter int CLKS_PER_BIT   = 10416,
    parameter int GAP_BITS       = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic send_connect,
    input  logic send_start,
    input  logic send_game_finish,
    input  logic rx,
    output logic tx,
    output logic receive_connect,
    output logic receive_start,
    output logic receive_game_finish,
    output logic link_up,
    output logic frame_error
);

    localparam int GAP_CYC  = (GAP_BITS > 0) ? GAP_BITS * CLKS_PER_BIT : 1;
    localparam int HALF_CYC = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;

    localparam logic [31:0] BIT_LAST  = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);
    localparam logic [31:0] HALF_LAST = 32'(HALF_CYC - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        T_GAP,
        T_START,
        T_DATA,
        T_PARITY,
        T_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_PARITY,
        R_STOP,
        R_WAIT_HIGH
    } rx_state_t;

    tx_state_t   tx_state;
    logic [31:0] tx_timer;
    logic [1:0]  tx_idx;
    logic [2:0]  tx_shift;
    logic        tx_par;

    logic        rx_meta;
    logic        rx_s;

    rx_state_t   rx_state;
    logic [31:0] rx_timer;
    logic [1:0]  rx_idx;
    logic [2:0]  rx_bits;
    logic        rx_par;
    logic [31:0] to_cnt;

    // Free-running frame generator; flags are captured as the gap ends
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= T_GAP;
            tx_timer <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            unique case (tx_state)
                T_GAP: begin
                    if (tx_timer == GAP_LAST) begin
                        tx_timer <= '0;
                        tx_shift <= {send_game_finish, send_start, send_connect};
                        tx_par   <= send_game_finish ^ send_start ^ send_connect;
                        tx       <= 1'b0;
                        tx_state <= T_START;
                    end else begin
                        tx_timer <= tx_timer + 32'd1;
                    end
                end
                T_START: begin
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        tx_idx   <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= T_DATA;
                    end else begin
                        tx_timer <= tx_timer + 32'd1;
                    end
                end
                T_DATA: begin
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        if (tx_idx == 2'd2) begin
                            tx       <= tx_par;
                            tx_state <= T_PARITY;
                        end else begin
                            tx_idx   <= tx_idx + 2'd1;
                            tx       <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_timer <= tx_timer + 32'd1;
                    end
                end
                T_PARITY: begin
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        tx       <= 1'b1;
                        tx_state <= T_STOP;
                    end else begin
                        tx_timer <= tx_timer + 32'd1;
                    end
                end
                T_STOP: begin
                    if (tx_timer == BIT_LAST) begin
                        tx_timer <= '0;
                        tx       <= 1'b1;
                        tx_state <= T_GAP;
                    end else begin
                        tx_timer <= tx_timer + 32'd1;
                    end
                end
                default: begin
                    tx_timer <= '0;
                    tx       <= 1'b1;
                    tx_state <= T_GAP;
                end
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous peer line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame receiver plus link supervision; a valid frame overrides timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state            <= R_IDLE;
            rx_timer            <= '0;
            rx_idx              <= '0;
            rx_bits             <= '0;
            rx_par              <= 1'b0;
            to_cnt              <= '0;
            receive_connect     <= 1'b0;
            receive_start       <= 1'b0;
            receive_game_finish <= 1'b0;
            link_up             <= 1'b0;
            frame_error         <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (to_cnt != TO_LAST) begin
                to_cnt <= to_cnt + 32'd1;
            end else begin
                link_up             <= 1'b0;
                receive_connect     <= 1'b0;
                receive_start       <= 1'b0;
                receive_game_finish <= 1'b0;
            end
            unique case (rx_state)
                R_IDLE: begin
                    rx_timer <= '0;
                    if (!rx_s) begin
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (rx_timer == HALF_LAST) begin
                        rx_timer <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        rx_timer <= rx_timer + 32'd1;
                    end
                end
                R_DATA: begin
                    if (rx_timer == BIT_LAST) begin
                        rx_timer <= '0;
                        rx_bits  <= {rx_s, rx_bits[2:1]};
                        if (rx_idx == 2'd2) begin
                            rx_state <= R_PARITY;
                        end else begin
                            rx_idx <= rx_idx + 2'd1;
                        end
                    end else begin
                        rx_timer <= rx_timer + 32'd1;
                    end
                end
                R_PARITY: begin
                    if (rx_timer == BIT_LAST) begin
                        rx_timer <= '0;
                        rx_par   <= rx_s;
                        rx_state <= R_STOP;
                    end else begin
                        rx_timer <= rx_timer + 32'd1;
                    end
                end
                R_STOP: begin
                    if (rx_timer == BIT_LAST) begin
                        rx_timer <= '0;
                        if (rx_s && (rx_par == ^rx_bits)) begin
                            receive_connect     <= rx_bits[0];
                            receive_start       <= rx_bits[1];
                            receive_game_finish <= rx_bits[2];
                            link_up             <= 1'b1;
                            to_cnt              <= '0;
                            rx_state            <= R_IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            rx_state    <= rx_s ? R_IDLE : R_WAIT_HIGH;
                        end
                    end else begin
                        rx_timer <= rx_timer + 32'd1;
                    end
                end
                R_WAIT_HIGH: begin
                    rx_timer <= '0;
                    if (rx_s) begin
                        rx_state <= R_IDLE;
                    end
                end
                default: begin
                    rx_timer <= '0;
                    rx_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/link_flag_transceiver.md
LINK_FLAG_TRANSCEIVER -- requirements
Module: link_flag_transceiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10416, giving clock cycles per serial bit (9600 baud at 100 MHz).
REQ-002 The block SHALL have parameter GAP_BITS, default 2, giving idle-high bit times between transmitted frames.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 2000000, giving cycles without a valid frame before the link is declared down.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 send_connect  input  1  local connect request level, transmitted continuously.
REQ-007 send_start  input  1  local game-start level, transmitted continuously.
REQ-008 send_game_finish  input  1  local game-finished level, transmitted continuously.
REQ-009 rx  input  1  asynchronous serial line from peer board, idle high.
REQ-010 tx  output  1  serial line to peer board, idle high.
REQ-011 receive_connect / receive_start / receive_game_finish  output  1 each  last validated peer flags, registered.
REQ-012 link_up  output  1  high while valid frames arrive within TIMEOUT_CYCLES.
REQ-013 frame_error  output  1  one-cycle pulse per rejected frame.

Function
REQ-014 A frame SHALL be 6 bits, LSB first: start(0), connect, start, game_finish, parity, stop(1); parity = XOR of the three data bits (even parity).
REQ-015 Every bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, driven from a register.
REQ-016 TX FSM states: T_GAP, T_START, T_DATA (3 bits), T_PARITY, T_STOP; T_STOP -> T_GAP -> T_START with no handshake; frames repeat continuously.
REQ-017 T_GAP SHALL last GAP_BITS*CLKS_PER_BIT cycles with tx=1; frame period = (6+GAP_BITS)*CLKS_PER_BIT cycles.
REQ-018 The three send_* inputs SHALL be snapshotted on the T_GAP -> T_START transition; input changes mid-frame affect only the next frame.
REQ-019 rx SHALL pass through a 2-flop synchronizer; the RX FSM uses only the synchronized value.
REQ-020 RX FSM states: R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT_HIGH.
REQ-021 R_IDLE -> R_START on synchronized rx = 0; after CLKS_PER_BIT/2 cycles rx is re-sampled; 1 -> R_IDLE silently (glitch, no error), 0 -> R_DATA.
REQ-022 Data, parity and stop bits SHALL be sampled once each, CLKS_PER_BIT cycles apart, at mid-bit.
REQ-023 At stop sample, stop=1 and parity correct: receive_* load the 3 data bits, link_up=1, timeout counter cleared, all on the next edge; FSM -> R_IDLE.
REQ-024 Parity wrong or stop=0: frame_error pulses one cycle, receive_* and link_up unchanged; stop=0 -> R_WAIT_HIGH (wait for rx=1, then R_IDLE); otherwise -> R_IDLE.
REQ-025 Timeout counter SHALL increment every cycle and saturate; on reaching TIMEOUT_CYCLES-1: link_up=0 and all receive_* cleared to 0 the next cycle.
REQ-026 A valid frame completing in the same cycle as the timeout SHALL take priority (outputs load, link_up stays 1).
REQ-027 TX and RX SHALL operate independently; tx looped to rx is a legal configuration.

Reset
REQ-028 While reset=0: tx=1, receive_*=0, link_up=0, frame_error=0, TX in T_GAP with bit timer 0, RX in R_IDLE, synchronizer flops=1, timeout counter=0.
REQ-029 Reset asserted mid-frame SHALL abort both FSMs immediately; after release the first start bit appears after exactly GAP_BITS*CLKS_PER_BIT cycles.

Verification (CLKS_PER_BIT=4, GAP_BITS=2, TIMEOUT_CYCLES=200)
REQ-030 Loopback tx->rx, send_start=1, others 0 -> receive_start=1, link_up=1 within 2 frame periods (64 cycles); tx frame observed as 0,0,1,0,1,1.
REQ-031 Inject frame with flipped parity bit on rx -> frame_error one-cycle pulse, receive_* unchanged.
REQ-032 Hold rx=1 for 200 cycles after link_up -> link_up=0 and receive_*=0 at cycle 200.
REQ-033 1-cycle low glitch on rx in R_IDLE -> no frame_error, outputs unchanged, next real frame accepted.
REQ-034 rx held low 40 cycles (break) -> one frame_error, no further errors until rx returns high, then valid frame accepted.
REQ-035 Toggle send_connect mid-frame, then pulse reset low for 3 cycles -> tx=1 during reset; first start bit 8 cycles after release, carrying current send_* values.
